bcrypt_proxy_rx: RTL and testbench
==================================

Name: bcrypt_proxy_rx

Overview:
Arbiter-side receiver for the proxy output channel. It polls NUM_PROXIES proxies round-robin through their empty/rd_en handshake and captures each proxy's 1-bit serial result frame. Each frame is deserialized into a FRAME_BYTES-byte buffer and drained as a byte stream with valid/ready handshake toward the output packet builder. Timeouts and corrupt frames are reported on an error strobe.

Parameters:
NUM_PROXIES, 4, number of proxies polled (>=1)
FRAME_BYTES, 16, payload bytes per result frame (>=1)
START_TIMEOUT, 16, max cycles waiting for the start bit after rd_en (>=2)

Ports:
CLK  in  1  clock
rst  in  1  synchronous reset, active-high
proxy_empty  in  NUM_PROXIES  per-proxy empty; 0 = result available
proxy_rd_en  out  NUM_PROXIES  per-proxy read strobe, registered, one-hot 1-cycle pulse
proxy_dout  in  NUM_PROXIES  per-proxy serial data
out_data  out  8  payload byte
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts byte when out_valid & out_ready
out_last  out  1  high with final byte of frame
out_proxy_num  out  MSB(NUM_PROXIES-1)+1  source proxy of current frame
err  out  1  1-cycle error pulse
err_code  out  2  1 = start timeout, 2 = parity (only with the optional feature); held until the next err

Behaviour:
- Reset: state SCAN, ptr=0, proxy_rd_en=0, out_valid=0, out_last=0, err=0, err_code=0, out_data=0. A reset mid-frame discards any partial frame. No rd_en is issued in the reset cycle.
- SCAN: examine proxy_empty[ptr] once per cycle.
  - If 0: go to REQ.
  - Else: ptr <= (ptr==NUM_PROXIES-1) ? 0 : ptr+1.
- REQ: proxy_rd_en[ptr]=1 for exactly this one cycle; all other rd_en bits stay 0. The pulse appears the cycle after SCAN saw empty=0. Next state WAIT_START, timeout counter=0.
- WAIT_START: sample proxy_dout[ptr] each cycle.
  - A 1 is the start bit: go to SHIFT with bit counter=0.
  - Else increment the counter. When it reaches START_TIMEOUT: pulse err, err_code=1, ptr advances, go to SCAN.
- SHIFT: one data bit per cycle from proxy_dout[ptr], LSB-first within each byte, bytes in ascending order. Every 8th bit writes the assembled byte to buf[bit_cnt/8]. After FRAME_BYTES*8 bits go to DRAIN with rd_idx=0.
- DRAIN:
  - out_valid=1, out_data=buf[rd_idx], out_proxy_num=ptr, out_last=(rd_idx==FRAME_BYTES-1).
  - On out_valid & out_ready: rd_idx++.
  - On the last accepted byte: out_valid drops next cycle, ptr advances, go to SCAN.
  - out_ready low stalls indefinitely; data stays stable while stalled.
- No new rd_en is issued until the current frame is fully drained, so at most one frame is outstanding.
- Fairness: after any frame or error, polling resumes at ptr+1 with wrap. The same proxy is re-served only after the others have been examined.
- NUM_PROXIES=1: ptr stays 0.
- proxy_empty and proxy_dout of non-selected proxies are ignored.

Optional Feature:
BCRYPT_RX_PARITY_EN:
- Defined: the frame carries one extra bit after the payload, an even-parity bit over all FRAME_BYTES*8 data bits.
  - Mismatch: pulse err with err_code=2, skip DRAIN (no bytes output), ptr advances, go to SCAN.
  - Match: DRAIN proceeds normally.
- Undefined: frame is start bit + FRAME_BYTES*8 data bits, and err_code=2 never occurs.

Test Plan:
- FRAME_BYTES=4, proxy 2 drops empty and sends start bit 1 then bytes 0xA5,0x3C,0x00,0xFF LSB-first -> proxy_rd_en=4'b0100 for one cycle; out_data A5,3C,00,FF with out_proxy_num=2 and out_last on FF only.
- Proxies 0 and 3 both non-empty from reset -> proxy 0 served first, then proxy 3; then proxy 0 again only after 1 and 2 have been examined.
- Proxy 1 non-empty but dout stays 0 -> err=1 exactly START_TIMEOUT cycles into WAIT_START with err_code=1; no out_valid; next rd_en goes to a proxy other than 1 first.
- out_ready held 0 for 20 cycles mid-drain -> out_data and out_valid stable; no proxy_rd_en pulses; remaining bytes correct after release.
- rst asserted during SHIFT at bit 13 -> next cycle out_valid=0 and ptr=0; the following frame from proxy 0 is received intact.
- BCRYPT_RX_PARITY_EN defined, payload 0x01,0,0,0 with parity bit 0 -> err with err_code=2 and no output bytes; with parity bit 1 -> 4 bytes output.

Source files
------------

// File: rtl/bcrypt_proxy_rx.sv
// bcrypt_proxy_rx: round-robin poller and 1-bit serial frame receiver for the bcrypt proxies.
// Define BCRYPT_RX_PARITY_EN to expect a trailing even-parity bit after each frame payload.
`timescale 1ns/1ps
module bcrypt_proxy_rx #(
    parameter int NUM_PROXIES   = 4,
    parameter int FRAME_BYTES   = 16,
    parameter int START_TIMEOUT = 16,
    localparam int PW = (NUM_PROXIES > 1) ? $clog2(NUM_PROXIES) : 1
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic [NUM_PROXIES-1:0] proxy_empty,
    output logic [NUM_PROXIES-1:0] proxy_rd_en,
    input  logic [NUM_PROXIES-1:0] proxy_dout,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [PW-1:0]          out_proxy_num,
    output logic                   err,
    output logic [1:0]             err_code
);

    localparam int IW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int BW = $clog2(FRAME_BYTES * 8);
    localparam int TW = $clog2(START_TIMEOUT);

    typedef enum logic [2:0] {
        S_SCAN,
        S_REQ,
        S_WAIT_START,
        S_SHIFT,
`ifdef BCRYPT_RX_PARITY_EN
        S_PARITY,
`endif
        S_DRAIN
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  ptr_inc;
    logic [TW-1:0]  tcnt;
    logic [BW-1:0]  bit_cnt;
    logic [6:0]     shreg;
    logic [IW-1:0]  rd_idx;
    logic [IW-1:0]  wr_idx;
    logic [7:0]     fbuf [FRAME_BYTES];
`ifdef BCRYPT_RX_PARITY_EN
    logic           par;
`endif

    logic sel_empty;
    logic sel_dout;
    logic ptr_adv;
    logic req_fire;
    logic timeout;
    logic par_fail;

    assign sel_empty = proxy_empty[ptr];
    assign sel_dout  = proxy_dout[ptr];
    assign ptr_inc   = (ptr == PW'(NUM_PROXIES - 1)) ? '0 : ptr + PW'(1);
    assign wr_idx    = IW'(bit_cnt >> 3);

    always_ff @(posedge CLK) begin
        if (rst) state <= S_SCAN;
        else     state <= state_next;
    end

    // Next-state decode; the pointer only moves after an empty probe, a finished frame or an error.
    always_comb begin
        state_next = state;
        ptr_adv    = 1'b0;
        req_fire   = 1'b0;
        timeout    = 1'b0;
        par_fail   = 1'b0;
        case (state)
            S_SCAN: begin
                if (!sel_empty) begin
                    state_next = S_REQ;
                    req_fire   = 1'b1;
                end else begin
                    ptr_adv = 1'b1;
                end
            end
            S_REQ: state_next = S_WAIT_START;
            S_WAIT_START: begin
                if (sel_dout) begin
                    state_next = S_SHIFT;
                end else if (tcnt == TW'(START_TIMEOUT - 1)) begin
                    state_next = S_SCAN;
                    timeout    = 1'b1;
                    ptr_adv    = 1'b1;
                end
            end
            S_SHIFT: begin
                if (bit_cnt == BW'(FRAME_BYTES * 8 - 1)) begin
`ifdef BCRYPT_RX_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_DRAIN;
`endif
                end
            end
`ifdef BCRYPT_RX_PARITY_EN
            S_PARITY: begin
                if (par ^ sel_dout) begin
                    state_next = S_SCAN;
                    par_fail   = 1'b1;
                    ptr_adv    = 1'b1;
                end else begin
                    state_next = S_DRAIN;
                end
            end
`endif
            S_DRAIN: begin
                if (out_ready && out_last) begin
                    state_next = S_SCAN;
                    ptr_adv    = 1'b1;
                end
            end
            default: state_next = S_SCAN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            ptr         <= '0;
            proxy_rd_en <= '0;
            err         <= 1'b0;
            err_code    <= 2'd0;
            tcnt        <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            rd_idx      <= '0;
`ifdef BCRYPT_RX_PARITY_EN
            par         <= 1'b0;
`endif
        end else begin
            proxy_rd_en <= req_fire ? (NUM_PROXIES'(1) << ptr) : '0;
            err         <= timeout | par_fail;
            if (timeout)       err_code <= 2'd1;
            else if (par_fail) err_code <= 2'd2;
            if (ptr_adv) ptr <= ptr_inc;
            case (state)
                S_REQ: tcnt <= '0;
                S_WAIT_START: begin
                    tcnt    <= tcnt + TW'(1);
                    bit_cnt <= '0;
`ifdef BCRYPT_RX_PARITY_EN
                    par     <= 1'b0;
`endif
                end
                S_SHIFT: begin
                    shreg   <= {sel_dout, shreg[6:1]};
                    bit_cnt <= bit_cnt + BW'(1);
                    rd_idx  <= '0;
`ifdef BCRYPT_RX_PARITY_EN
                    par     <= par ^ sel_dout;
`endif
                end
                S_DRAIN: if (out_ready) rd_idx <= rd_idx + IW'(1);
                default: ;
            endcase
        end
    end

    // Bits arrive LSB-first, so the eighth bit completes the byte on top of the seven already shifted in.
    always_ff @(posedge CLK) begin
        if (state == S_SHIFT && bit_cnt[2:0] == 3'd7) fbuf[wr_idx] <= {sel_dout, shreg};
    end

    always_comb begin
        out_valid     = (state == S_DRAIN);
        out_last      = out_valid && (rd_idx == IW'(FRAME_BYTES - 1));
        out_data      = out_valid ? fbuf[rd_idx] : 8'h00;
        out_proxy_num = ptr;
    end

endmodule

// File: tb/tb_bcrypt_proxy_rx.sv
// Self-checking bench for bcrypt_proxy_rx: a per-cycle proxy model feeds serial frames and
// a scoreboard of expected bytes / error codes is compared against the output stream.
`timescale 1ns/1ps
module tb_bcrypt_proxy_rx;

    localparam int NP = 4;
    localparam int FB = 4;
    localparam int ST = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [1:0] pnum;
    } exp_t;

    logic          CLK = 1'b0;
    logic          rst;
    logic [NP-1:0] proxy_empty;
    logic [NP-1:0] proxy_rd_en;
    logic [NP-1:0] proxy_dout;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [1:0]    out_proxy_num;
    logic          err;
    logic [1:0]    err_code;

    bcrypt_proxy_rx #(
        .NUM_PROXIES   (NP),
        .FRAME_BYTES   (FB),
        .START_TIMEOUT (ST)
    ) dut (
        .CLK           (CLK),
        .rst           (rst),
        .proxy_empty   (proxy_empty),
        .proxy_rd_en   (proxy_rd_en),
        .proxy_dout    (proxy_dout),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .out_proxy_num (out_proxy_num),
        .err           (err),
        .err_code      (err_code)
    );

    always #5 CLK = ~CLK;

    int         pend [NP];
    bit         mute [NP];
    logic [7:0] pay  [NP][FB];
`ifdef BCRYPT_RX_PARITY_EN
    bit         bad_par [NP];
`endif
    bit            txq [$];
    int            txp, tx_pos, tx_lead;
    exp_t          sb [$];
    int            exp_err_q [$];
    int            rd_log [$];
    int            rd_cyc_log [$];
    logic [NP-1:0] last_rd_vec;
    bit            busy, prev_err, prev_rd, ready_cmd;
    int            cyc, err_cyc, acc_cnt;
    int            n_checks, n_fail;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit pend_any();
        for (int i = 0; i < NP; i++) if (pend[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int rd_at(input int i);
        return (i < rd_log.size()) ? rd_log[i] : -1;
    endfunction

    function automatic int rd_cyc_at(input int i);
        return (i < rd_cyc_log.size()) ? rd_cyc_log[i] : -1000;
    endfunction

    // One clock of the environment: observe outputs at the falling edge, then drive the proxies.
    task automatic cycle();
        exp_t e;
        int   p;
        bit   pb;
        @(negedge CLK);
        cyc++;
        out_ready = ready_cmd;
        if (err) begin
            check_output("err_pulse_width", prev_err, 0);
            if (exp_err_q.size() == 0) check_output("err_unexpected", err, 0);
            else                       check_output("err_code", err_code, exp_err_q.pop_front());
            err_cyc = cyc;
            busy    = 1'b0;
        end
        prev_err = err;
        if (out_valid) begin
            if (sb.size() == 0) begin
                check_output("valid_unexpected", out_valid, 0);
            end else if (out_ready) begin
                e = sb.pop_front();
                check_output("out_data", out_data, e.data);
                check_output("out_last", out_last, e.last);
                check_output("out_proxy_num", out_proxy_num, e.pnum);
                acc_cnt++;
                if (e.last) busy = 1'b0;
            end
        end
        proxy_dout = '0;
        if (rst) begin
            txq.delete();
        end else if (txq.size() > 0) begin
            proxy_dout[txp] = txq.pop_front();
            tx_pos++;
        end
        if (proxy_rd_en != '0) begin
            check_output("rd_onehot", $countones(proxy_rd_en), 1);
            check_output("rd_pulse_width", prev_rd, 0);
            check_output("rd_one_outstanding", busy, 0);
            p = 0;
            for (int i = 0; i < NP; i++) if (proxy_rd_en[i]) p = i;
            check_output("rd_target_nonempty", pend[p] > 0, 1);
            if (pend[p] > 0) pend[p]--;
            rd_log.push_back(p);
            rd_cyc_log.push_back(cyc);
            last_rd_vec = proxy_rd_en;
            busy        = 1'b1;
            txq.delete();
            txp     = p;
            tx_pos  = 0;
            tx_lead = 0;
            if (mute[p]) begin
                exp_err_q.push_back(1);
            end else begin
                txq.push_back(1'b0);
                txq.push_back(1'b1);
                tx_lead = 2;
                pb      = 1'b0;
                for (int b = 0; b < FB; b++)
                    for (int k = 0; k < 8; k++) begin
                        txq.push_back(pay[p][b][k]);
                        pb ^= pay[p][b][k];
                    end
`ifdef BCRYPT_RX_PARITY_EN
                txq.push_back(pb ^ bad_par[p]);
                if (bad_par[p]) exp_err_q.push_back(2);
                else for (int b = 0; b < FB; b++) sb.push_back('{pay[p][b], b == FB - 1, 2'(p)});
`else
                for (int b = 0; b < FB; b++) sb.push_back('{pay[p][b], b == FB - 1, 2'(p)});
`endif
            end
        end
        prev_rd = (proxy_rd_en != '0);
        for (int i = 0; i < NP; i++) proxy_empty[i] = (pend[i] == 0);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((busy || pend_any() || sb.size() > 0 || exp_err_q.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        check_output("wait_done", busy || pend_any() || sb.size() > 0 || exp_err_q.size() > 0, 0);
        repeat (2) cycle();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        sb.delete();
        exp_err_q.delete();
        rd_log.delete();
        rd_cyc_log.delete();
        busy = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;
    endtask

    task automatic apply_stimulus(input int p);
        for (int b = 0; b < FB; b++) pay[p][b] = 8'($urandom);
        pend[p]++;
    endtask

    initial begin
        int a0, n;
        rst = 1'b1; out_ready = 1'b1; ready_cmd = 1'b1;
        proxy_empty = '1; proxy_dout = '0;
        for (int i = 0; i < NP; i++) begin
            pend[i] = 0; mute[i] = 1'b0;
`ifdef BCRYPT_RX_PARITY_EN
            bad_par[i] = 1'b0;
`endif
            for (int b = 0; b < FB; b++) pay[i][b] = 8'h00;
        end
        repeat (3) cycle();
        check_output("rst_rd_en", proxy_rd_en, 0);
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_out_last", out_last, 0);
        check_output("rst_err", err, 0);
        check_output("rst_err_code", err_code, 0);
        check_output("rst_out_data", out_data, 0);
        rst = 1'b0;

        $display("[TB] basic frame from proxy 2");
        pay[2] = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
        pend[2] = 1;
        wait_done(300);
        check_output("t1_rd_proxy", rd_at(0), 2);
        check_output("t1_rd_vec", last_rd_vec, 4'b0100);

        $display("[TB] fairness with proxies 0 and 3 pending from reset");
        apply_stimulus(0); pend[0] = 2; apply_stimulus(3);
        apply_reset();
        wait_done(600);
        check_output("t2_order0", rd_at(0), 0);
        check_output("t2_order1", rd_at(1), 3);
        check_output("t2_order2", rd_at(2), 0);

        $display("[TB] start-bit timeout on proxy 1");
        mute[1] = 1'b1; pend[1] = 1; apply_stimulus(3);
        apply_reset();
        wait_done(600);
        check_output("t3_order0", rd_at(0), 1);
        check_output("t3_order1", rd_at(1), 3);
        check_output("t3_err_latency", err_cyc - rd_cyc_at(0), ST + 1);
        check_output("t3_err_code_held", err_code, 1);
        mute[1] = 1'b0;

        $display("[TB] consumer stall mid-drain");
        rd_log.delete();
        a0 = acc_cnt; n = 0;
        apply_stimulus(2);
        while (acc_cnt < a0 + 2 && n < 300) begin cycle(); n++; end
        check_output("t4_reach_drain", acc_cnt - a0, 2);
        ready_cmd = 1'b0;
        apply_stimulus(0);
        repeat (20) begin
            cycle();
            check_output("t4_stall_valid", out_valid, 1);
            check_output("t4_stall_data", out_data, (sb.size() > 0) ? {24'h0, sb[0].data} : 32'hFFFF_FFFF);
            check_output("t4_stall_rd_en", proxy_rd_en, 0);
        end
        ready_cmd = 1'b1;
        wait_done(400);
        check_output("t4_order0", rd_at(0), 2);
        check_output("t4_order1", rd_at(1), 0);

        $display("[TB] reset during shift");
        rd_log.delete();
        apply_stimulus(1);
        n = 0;
        while (!(rd_log.size() > 0 && txp == 1 && tx_pos - tx_lead == 13) && n < 300) begin cycle(); n++; end
        check_output("t5_reach_bit13", tx_pos - tx_lead, 13);
        apply_stimulus(0); apply_stimulus(2);
        rst = 1'b1;
        sb.delete(); exp_err_q.delete(); rd_log.delete(); rd_cyc_log.delete();
        busy = 1'b0;
        cycle();
        check_output("t5_rst_valid", out_valid, 0);
        check_output("t5_rst_rd_en", proxy_rd_en, 0);
        rst = 1'b0;
        wait_done(600);
        check_output("t5_order0", rd_at(0), 0);
        check_output("t5_order1", rd_at(1), 2);

`ifdef BCRYPT_RX_PARITY_EN
        $display("[TB] parity trailer");
        pay[3] = '{8'h01, 8'h00, 8'h00, 8'h00};
        bad_par[3] = 1'b1; pend[3] = 1; a0 = acc_cnt;
        wait_done(400);
        check_output("t6_bad_par_bytes", acc_cnt - a0, 0);
        check_output("t6_bad_par_code", err_code, 2);
        bad_par[3] = 1'b0; pend[3] = 1; a0 = acc_cnt;
        wait_done(400);
        check_output("t6_good_par_bytes", acc_cnt - a0, FB);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
